// File: rtl/plot_writer.sv
// plot_writer: takes finished escape-time results, maps each to an RRGGBB
// colour, buffers them in a small FIFO and drives the VGA adapter plot port
// at up to one pixel per cycle. Counts plots and pulses frame_done on the
// final pixel of a frame.
// Build option: define MONO_PALETTE_EN for a two-colour (black/white) palette.
module plot_writer #(
  parameter int DEPTH  = 4,
  parameter int LAST_X = 0,
  parameter int LAST_Y = 240
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [8:0]               i_in_x,
  input  logic [7:0]               i_in_y,
  input  logic [5:0]               i_in_count,
  input  logic                     i_in_diverge,
  input  logic                     i_pause,
  output logic                     o_plot,
  output logic [8:0]               o_plot_x,
  output logic [7:0]               o_plot_y,
  output logic [5:0]               o_plot_colour,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [16:0]              o_pixels_plotted,
  output logic                     o_frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [8:0]    FRAME_X    = 9'(LAST_X);
  localparam logic [7:0]    FRAME_Y    = 8'(LAST_Y);

  logic [22:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          r_plot;
  logic [8:0]    r_plot_x;
  logic [7:0]    r_plot_y;
  logic [5:0]    r_plot_colour;
  logic [16:0]   r_pixels;
  logic          r_frame_done;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [5:0]    w_colour;
  logic [22:0]   w_head;
  logic [8:0]    w_head_x;
  logic [7:0]    w_head_y;
  logic [5:0]    w_head_colour;
  logic          w_head_last;

  assign w_full     = (r_level == FULL_LEVEL);
  assign o_in_ready = !w_full;
  // a full FIFO refuses a push even when the same edge pops
  assign w_push     = i_in_valid && !w_full;
  assign w_pop      = (r_level != '0) && !i_pause;

  assign w_head        = r_mem[r_rptr];
  assign w_head_x      = w_head[22:14];
  assign w_head_y      = w_head[13:6];
  assign w_head_colour = w_head[5:0];
  assign w_head_last   = (w_head_x == FRAME_X) && (w_head_y == FRAME_Y);

  // Colour mapping at push time; escaped points are never black.
  always_comb begin
    w_colour = 6'b000000;
`ifdef MONO_PALETTE_EN
    if (i_in_diverge) w_colour = 6'b111111;
`else
    if (i_in_diverge) begin
      w_colour = {i_in_count[1:0], i_in_count[3:2], i_in_count[5:4]};
      if (w_colour == 6'b000000) w_colour = 6'b000001;
    end
`endif
  end

  // FIFO storage write; contents need no reset since pointers are cleared.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_push) r_mem[r_wptr] <= {i_in_x, i_in_y, w_colour};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Plot port, pixel counter and end-of-frame pulse, registered on pop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_plot        <= 1'b0;
      r_plot_x      <= '0;
      r_plot_y      <= '0;
      r_plot_colour <= '0;
      r_pixels      <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_plot       <= w_pop;
      r_frame_done <= w_pop && w_head_last;
      if (w_pop) begin
        r_plot_x      <= w_head_x;
        r_plot_y      <= w_head_y;
        r_plot_colour <= w_head_colour;
        r_pixels      <= w_head_last ? 17'd0 : r_pixels + 17'd1;
      end
    end
  end

  assign o_plot           = r_plot;
  assign o_plot_x         = r_plot_x;
  assign o_plot_y         = r_plot_y;
  assign o_plot_colour    = r_plot_colour;
  assign o_level          = r_level;
  assign o_pixels_plotted = r_pixels;
  assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_plot_writer.sv
// Bench for plot_writer (default parameters): scoreboard of expected pixels
// filled at acceptance and checked by a monitor on every plot strobe.
module tb_plot_writer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [8:0]  i_in_x = '0;
  logic [7:0]  i_in_y = '0;
  logic [5:0]  i_in_count = '0;
  logic        i_in_diverge = 1'b0;
  logic        i_pause = 1'b0;
  logic        o_plot;
  logic [8:0]  o_plot_x;
  logic [7:0]  o_plot_y;
  logic [5:0]  o_plot_colour;
  logic [2:0]  o_level;
  logic [16:0] o_pixels_plotted;
  logic        o_frame_done;

  always #5 clk = ~clk;

  plot_writer dut (
    .i_clock(clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_x(i_in_x), .i_in_y(i_in_y), .i_in_count(i_in_count), .i_in_diverge(i_in_diverge),
    .i_pause(i_pause), .o_plot(o_plot), .o_plot_x(o_plot_x), .o_plot_y(o_plot_y),
    .o_plot_colour(o_plot_colour), .o_level(o_level), .o_pixels_plotted(o_pixels_plotted),
    .o_frame_done(o_frame_done)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_pp = 0;
  int   fd_count = 0;
  int   pp_before_fd = -1;

`ifdef MONO_PALETTE_EN
  localparam logic [5:0] C_COUNT5 = 6'b111111;
  localparam logic [5:0] C_COUNT0 = 6'b111111;
`else
  localparam logic [5:0] C_COUNT5 = 6'b010100;
  localparam logic [5:0] C_COUNT0 = 6'b000001;
`endif

  function automatic logic [5:0] colour_of(input logic [5:0] cnt, input logic dv);
    logic [5:0] p;
    p = 6'b000000;
`ifdef MONO_PALETTE_EN
    if (dv) p = 6'b111111;
`else
    if (dv) begin
      p = {cnt[1:0], cnt[3:2], cnt[5:4]};
      if (p == 6'b000000) p = 6'b000001;
    end
`endif
    return p;
  endfunction

  // Monitor: every plot strobe must match the scoreboard head.
  always @(negedge clk) begin
    pix_t e;
    logic fd_exp;
    if (!i_reset) begin
      if (o_plot) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL plot_unexpected x=%0d y=%0d", o_plot_x, o_plot_y);
        end else begin
          e = exp_q.pop_front();
          if ({o_plot_x, o_plot_y, o_plot_colour} !== e) begin
            n_fail++;
            $display("FAIL plot_data got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b",
                     o_plot_x, o_plot_y, o_plot_colour, e.x, e.y, e.c);
          end
          fd_exp = (e.x == 9'd0) && (e.y == 8'd240);
          n_checks++;
          if (o_frame_done !== fd_exp) begin
            n_fail++;
            $display("FAIL frame_done got %b want %b", o_frame_done, fd_exp);
          end
          if (fd_exp) begin
            fd_count++;
            pp_before_fd = exp_pp;
            exp_pp = 0;
          end else begin
            exp_pp++;
          end
        end
      end else begin
        n_checks++;
        if (o_frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_done_idle got %b want 0", o_frame_done);
        end
      end
      n_checks++;
      if (o_pixels_plotted !== 17'(exp_pp)) begin
        n_fail++;
        $display("FAIL pixels_plotted got %0d want %0d", o_pixels_plotted, exp_pp);
      end
    end
  end

  // Present one result and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [5:0] c, input logic d);
    bit acc;
    acc = 0;
    i_in_valid = 1'b1; i_in_x = x; i_in_y = y; i_in_count = c; i_in_diverge = d;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      if (o_in_ready) begin
        acc = 1;
        exp_q.push_back({x, y, colour_of(c, d)});
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout got no_accept want accept x=%0d y=%0d", x, y);
    end
  endtask

  task automatic idle();
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || o_level != 0); i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || o_level !== 3'd0) begin
      n_fail++;
      $display("FAIL drain got pending=%0d level=%0d want 0 0", exp_q.size(), o_level);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    exp_q.delete();
    exp_pp = 0;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_in_valid = 1'b0; i_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_plot, o_plot_x, o_plot_y, o_plot_colour} !== '0) begin
      n_fail++;
      $display("FAIL reset_plot got %b/%0d/%0d/%b want 0", o_plot, o_plot_x, o_plot_y, o_plot_colour);
    end
    n_checks++;
    if (o_level !== 3'd0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_level got level=%0d ready=%b want 0 1", o_level, o_in_ready);
    end
    n_checks++;
    if (o_pixels_plotted !== 17'd0 || o_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_counter got pp=%0d fd=%b want 0 0", o_pixels_plotted, o_frame_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_first_pixel();
    i_in_valid = 1'b1; i_in_x = 9'd320; i_in_y = 8'd0; i_in_count = 6'd5; i_in_diverge = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ready got %b want 1", o_in_ready);
    end
    exp_q.push_back({9'd320, 8'd0, C_COUNT5});
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_plot !== 1'b0) begin
      n_fail++;
      $display("FAIL first_plot_early got %b want 0", o_plot);
    end
    @(negedge clk);
    n_checks++;
    if (o_plot !== 1'b1 || o_plot_x !== 9'd320 || o_plot_y !== 8'd0 || o_plot_colour !== C_COUNT5) begin
      n_fail++;
      $display("FAIL first_plot got p=%b x=%0d y=%0d c=%b want 1 320 0 %b",
               o_plot, o_plot_x, o_plot_y, o_plot_colour, C_COUNT5);
    end
    n_checks++;
    if (o_pixels_plotted !== 17'd1) begin
      n_fail++;
      $display("FAIL first_count got %0d want 1", o_pixels_plotted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_colours();
    logic [5:0] c1, c2;
    logic       p2;
    bit         seen;
    c1 = '0; c2 = '0; p2 = 1'b0; seen = 0;
    fork
      begin
        send(9'd10, 8'd3, 6'd0, 1'b1);
        send(9'd9, 8'd3, 6'd63, 1'b0);
        idle();
      end
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (o_plot) seen = 1;
        end
        c1 = o_plot_colour;
        @(negedge clk);
        p2 = o_plot; c2 = o_plot_colour;
      end
    join
    n_checks++;
    if (!seen || c1 !== C_COUNT0) begin
      n_fail++;
      $display("FAIL colour_first got seen=%0d c=%b want 1 %b", seen, c1, C_COUNT0);
    end
    n_checks++;
    if (p2 !== 1'b1 || c2 !== 6'b000000) begin
      n_fail++;
      $display("FAIL colour_second got p=%b c=%b want 1 000000", p2, c2);
    end
    drain();
  endtask

  task automatic test_pause();
    int run;
    bit seen;
    run = 0; seen = 0;
    i_pause = 1'b1;
    for (int i = 0; i < 4; i++) send(9'(100 + i), 8'd20, 6'(i * 7 + 1), 1'b1);
    fork
      begin
        send(9'd104, 8'd20, 6'd33, 1'b1);
        send(9'd105, 8'd21, 6'd12, 1'b0);
        idle();
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          n_checks++;
          if (o_in_ready !== 1'b0 || o_level !== 3'd4 || o_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_full got ready=%b level=%0d plot=%b want 0 4 0",
                     o_in_ready, o_level, o_plot);
          end
        end
        @(posedge clk); #1;
        i_pause = 1'b0;
      end
      begin
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          if (o_plot) seen = 1;
        end
        while (seen && o_plot && run < 20) begin
          run++;
          @(negedge clk);
        end
      end
    join
    n_checks++;
    if (run != 6) begin
      n_fail++;
      $display("FAIL pause_release_run got %0d want 6", run);
    end
    drain();
  endtask

  task automatic test_continuous();
    int max_lvl, plots;
    max_lvl = 0; plots = 0;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(9'($urandom_range(1, 320)), 8'($urandom_range(0, 240)),
               6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
          if (o_plot) plots++;
        end
      end
    join
    n_checks++;
    if (max_lvl != 1) begin
      n_fail++;
      $display("FAIL stream_level got %0d want 1", max_lvl);
    end
    n_checks++;
    if (plots != 12) begin
      n_fail++;
      $display("FAIL stream_plots got %0d want 12", plots);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int stray;
    stray = 0;
    i_pause = 1'b1;
    for (int i = 0; i < 3; i++) send(9'(50 + i), 8'd60, 6'd9, 1'b1);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_level !== 3'd3) begin
      n_fail++;
      $display("FAIL midreset_fill got %0d want 3", o_level);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (o_level !== 3'd0 || o_plot !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear got level=%0d plot=%b want 0 0", o_level, o_plot);
    end
    @(posedge clk); #1;
    i_pause = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_plot !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL midreset_stray got %0d want 0", stray);
    end
    @(posedge clk); #1;
    send(9'd77, 8'd77, 6'd7, 1'b1);
    idle();
    drain();
    n_checks++;
    if (o_pixels_plotted !== 17'd1) begin
      n_fail++;
      $display("FAIL midreset_after got %0d want 1", o_pixels_plotted);
    end
  endtask

  task automatic test_frame();
    do_reset();
    fd_count = 0;
    pp_before_fd = -1;
    for (int i = 0; i < 19; i++)
      send(9'($urandom_range(1, 320)), 8'($urandom_range(0, 240)), 6'(i), 1'b1);
    send(9'd1, 8'd240, 6'd3, 1'b1);
    send(9'd0, 8'd239, 6'd4, 1'b1);
    send(9'd0, 8'd240, 6'd5, 1'b1);
    send(9'd320, 8'd0, 6'd6, 1'b1);
    send(9'd319, 8'd0, 6'd7, 1'b0);
    idle();
    drain();
    n_checks++;
    if (fd_count != 1) begin
      n_fail++;
      $display("FAIL frame_pulses got %0d want 1", fd_count);
    end
    n_checks++;
    if (pp_before_fd != 21) begin
      n_fail++;
      $display("FAIL frame_count_before got %0d want 21", pp_before_fd);
    end
    n_checks++;
    if (o_pixels_plotted !== 17'd2) begin
      n_fail++;
      $display("FAIL frame_count_after got %0d want 2", o_pixels_plotted);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_colours();
    test_pause();
    test_continuous();
    test_mid_reset();
    test_frame();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_writer.md
Name: plot_writer

Overview:
- Downstream of the escape-time function unit. Accepts one finished pixel result per handshake: screen X/Y, iteration count and diverge flag.
- Maps each result to a 6-bit RRGGBB colour and buffers it in a small FIFO.
- Drives the VGA adapter's plot/x/y/colour inputs, one plot per pixel, independent of iteration timing.
- Counts plotted pixels and flags completion of each 321x241 frame.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LAST_X, 0, X coordinate of the final pixel of a frame.
- LAST_Y, 240, Y coordinate of the final pixel of a frame.

Ports:
- clock, input, 1, system clock (CLOCK_50 domain).
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, result presented this cycle.
- in_ready, output, 1, block can accept a result this cycle.
- in_x, input, 9, pixel X (0..320).
- in_y, input, 8, pixel Y (0..240).
- in_count, input, 6, iterations performed.
- in_diverge, input, 1, point escaped.
- pause, input, 1, hold off plotting; FIFO keeps filling.
- plot, output, 1, one-cycle write strobe to the VGA adapter.
- plot_x, output, 9, X for current plot.
- plot_y, output, 8, Y for current plot.
- plot_colour, output, 6, RRGGBB for current plot.
- level, output, clog2(DEPTH)+1, FIFO occupancy.
- pixels_plotted, output, 17, plots issued since reset or last frame.
- frame_done, output, 1, one-cycle pulse with the plot of (LAST_X, LAST_Y).

Behaviour:
- Reset (synchronous, active-high, clock edge with reset=1): FIFO emptied, level=0, plot=0, plot_x=0, plot_y=0, plot_colour=0, pixels_plotted=0, frame_done=0. Reset overrides any push or pop in the same cycle. Reset mid-frame discards all buffered pixels.
- in_ready = (level != DEPTH), combinational from registered level. Push occurs when in_valid && in_ready at a clock edge.
- No push is accepted when full, even if a pop occurs the same edge.
- Colour mapping is computed combinationally at push; the FIFO stores {x, y, colour}.
  - in_diverge=0 -> 6'b000000.
  - in_diverge=1 -> {in_count[1:0], in_count[3:2], in_count[5:4]}; if that result is 6'b000000, substitute 6'b000001 so escaped points are never black.
- Pop: at an edge where level != 0 and pause == 0, the head entry is removed, plot_x/plot_y/plot_colour are registered from it, and plot=1 for the following cycle. Otherwise plot=0 and plot_x/y/colour hold their last values.
- Maximum rate is one plot per cycle.
- Latency, empty FIFO and pause=0: pushed at edge N, popped at edge N+1, plot high during the cycle after edge N+1.
- Simultaneous push and pop (not full): level unchanged, ordering preserved, strict FIFO.
- Read and write pointers are clog2(DEPTH) bits and wrap naturally. level is tracked separately.
- pixels_plotted increments on each pop.
- frame_done is registered alongside plot: it is 1 when the popped entry has x==LAST_X and y==LAST_Y. On that same edge pixels_plotted is cleared to 0 instead of incrementing.
- pause asserted mid-stream: no pop on any edge where pause=1. Pending entries are retained; in_ready deasserts once full.

Optional Feature:
- Macro MONO_PALETTE_EN.
  - Defined: colour mapping ignores in_count. Diverged -> 6'b111111, not diverged -> 6'b000000.
  - Undefined: count-based palette as above.
- All handshake and timing is identical in both builds.

Test Plan:
- Reset, then push (x=320, y=0, count=5, diverge=1) with pause=0 -> plot=1 exactly 2 cycles after acceptance, plot_x=320, plot_y=0, plot_colour=6'b010100, pixels_plotted=1.
- Push (x=10, y=3, count=0, diverge=1), then (x=9, y=3, count=63, diverge=0) -> colours 6'b000001 then 6'b000000, on consecutive cycles, in order.
- pause=1, push 6 results back to back with DEPTH=4 -> in_ready drops after 4 accepts, level=4, no plot; release pause -> 4 plots on consecutive cycles, then remaining 2 accepted and plotted, order intact.
- Push continuously with pause=0 and in_valid held -> level never exceeds 1, one plot per cycle.
- Stream a full frame (X 320..0 per row, Y 0..240) -> frame_done pulses once with plot of (0,240), pixels_plotted reaches 77360 before clearing to 0 on that pulse.
- Fill 3 entries under pause, assert reset for 1 cycle -> level=0, plot stays 0 after pause release, and a subsequent push plots normally.
- With MONO_PALETTE_EN defined, count=5, diverge=1 -> plot_colour=6'b111111.
